rr_lock_arbiter: RTL
====================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, max consecutive grant cycles while another requester waits; legal range 2..255.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 en  input  1  arbitration enable; 0 blocks new grants but does not revoke a current grant.
REQ-005 req  input  4  request per requester; held high for the whole time the requester uses the resource.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when the resource is free.
REQ-007 gnt_id  output  2  registered index of current owner; valid only while busy=1.
REQ-008 busy  output  1  registered, equals OR of gnt.
REQ-009 preempt  output  1  registered one-cycle pulse when a grant is revoked by hold timeout.

Function
REQ-010 The block SHALL implement two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 The block SHALL hold a 2-bit priority pointer ptr; the winner is the first requester with req high, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-012 IDLE -> GRANT: at an edge where en=1 and req!=0, the block SHALL set gnt to onehot(winner), gnt_id=winner, busy=1, hold_cnt=0.
REQ-013 Grant latency SHALL be 1 cycle: req sampled high at edge E in IDLE gives gnt high from E onward (visible in the cycle after E).
REQ-014 IDLE with en=0 or req=0 SHALL remain IDLE with all outputs 0.
REQ-015 GRANT -> IDLE (release): at an edge where req[gnt_id]=0, the block SHALL clear gnt and busy and set ptr=gnt_id+1 mod 4.
REQ-016 After any GRANT -> IDLE transition, at least one cycle with gnt=0 SHALL occur before the next grant.
REQ-017 In GRANT, hold_cnt (8 bit) SHALL increment each cycle and saturate at HOLD_MAX-1.
REQ-018 Preempt: at an edge in GRANT where hold_cnt==HOLD_MAX-1, req[gnt_id]=1 and (req & ~gnt)!=0, the block SHALL go to IDLE, set ptr=gnt_id+1 mod 4 and pulse preempt=1 for exactly one cycle.
REQ-019 A preempted grant SHALL therefore last exactly HOLD_MAX cycles.
REQ-020 With no other requester pending, the owner SHALL keep the grant indefinitely; preemption SHALL occur at the first edge another req is seen after saturation.
REQ-021 Release takes precedence: if req[gnt_id]=0 on the preempt edge, preempt SHALL stay 0.
REQ-022 A preempted requester with req still high SHALL re-arbitrate normally; its position after ptr means it loses to other pending requesters.
REQ-023 en SHALL have no effect in GRANT; release and preempt proceed regardless of en.
REQ-024 Changes on req bits other than gnt_id SHALL not affect gnt while in GRANT, except through preempt.
REQ-025 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-026 At an edge with reset=1, the block SHALL force IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0, ptr=0, overriding all other inputs including a grant in progress.
REQ-027 The first arbitration after reset SHALL start from ptr=0 (requester 0 highest).

Verification
REQ-028 Reset, then req=4'b1010, en=1 -> next cycle gnt=4'b0010, gnt_id=1, busy=1.
REQ-029 Owner 1 drops req at edge E with req[3] high -> gnt=0 after E; gnt=4'b1000 after E+1 (ptr=2, 2 idle, 3 wins).
REQ-030 HOLD_MAX=8, req=4'b0011 held constant from reset -> gnt=0001 for 8 cycles, preempt pulse 1 cycle with gnt=0, then gnt=0010 for 8 cycles; pattern alternates with no overlap.
REQ-031 req=4'b0001 alone for 50 cycles -> gnt=0001 continuously, preempt never 1; raise req[2] at cycle 50 -> gnt=0 with preempt=1 on the next cycle, then gnt=0100.
REQ-032 en=0 with req=4'b1111 -> gnt stays 0; en=0 asserted during an active grant -> grant continues until owner releases, then no new grant.
REQ-033 reset asserted for 1 cycle mid-grant (gnt=0100) -> gnt=0, busy=0 next cycle; with req=4'b1111 afterwards, the next grant is 0001.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter for four requesters. A granted requester keeps the
// resource until it drops req or overstays HOLD_MAX cycles while others wait.
module rr_lock_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       preempt,
   output logic       dbg_state
);

   // Handshake: a requester raises req and holds it for the whole time it uses
   // the resource. gnt (one-hot) and gnt_id are valid while busy=1. Dropping req
   // while granted releases the resource at the next clock edge. No bit of req
   // ever revokes another requester's grant except through the hold timeout.

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state;
   logic [1:0] ptr;
   logic [7:0] hold_cnt;

   logic [1:0] win_id;
   logic       win_found;
   logic [1:0] scan_idx;
   logic       owner_req;
   logic       others_pending;
   logic       hold_expired;

   // Search from ptr upward; scanning offsets in reverse lets the nearest
   // requester overwrite farther ones.
   always_comb begin
      win_id    = 2'd0;
      win_found = 1'b0;
      scan_idx  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         scan_idx = ptr + 2'(i);
         if (req[scan_idx]) begin
            win_id    = scan_idx;
            win_found = 1'b1;
         end
      end
   end

   assign owner_req      = req[gnt_id];
   assign others_pending = |(req & ~gnt);
   assign hold_expired   = (hold_cnt == HOLD_LAST);
   assign dbg_state      = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         gnt      <= 4'b0000;
         gnt_id   <= 2'd0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
         hold_cnt <= 8'd0;
         ptr      <= 2'd0;
      end else begin
         preempt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en && win_found) begin
                  state    <= ST_GRANT;
                  gnt      <= 4'b0001 << win_id;
                  gnt_id   <= win_id;
                  busy     <= 1'b1;
                  hold_cnt <= 8'd0;
               end
            end
            ST_GRANT: begin
               // Release wins over timeout, so preempt only fires while the
               // owner still wants the resource.
               if (!owner_req) begin
                  state    <= ST_IDLE;
                  gnt      <= 4'b0000;
                  busy     <= 1'b0;
                  hold_cnt <= 8'd0;
                  ptr      <= gnt_id + 2'd1;
               end else if (hold_expired && others_pending) begin
                  state    <= ST_IDLE;
                  gnt      <= 4'b0000;
                  busy     <= 1'b0;
                  hold_cnt <= 8'd0;
                  ptr      <= gnt_id + 2'd1;
                  preempt  <= 1'b1;
               end else if (!hold_expired) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= 4'b0000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
